lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Parametrised MEM-stage load/store unit for the RV32/RV64 pipeline. It replaces the pass-through memory stage with byte/half/word(/double) access sizing, byte enables, load sign/zero extension, misalignment detection and a request/acknowledge data-memory handshake. It sits between the EX/MEM and MEM/WB registers, and it stalls the pipeline while a data-memory access is outstanding.

Parameters:
DATA_W, 32, data path width; legal values are 32 and 64. Byte lanes = DATA_W/8.
ADDR_W, 32, data memory address width.
TIMEOUT_CYCLES, 15, maximum REQ cycles without dmem_ack before a bus error; range 1..255.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  EX/MEM holds a valid instruction this cycle
alu_result  in  ADDR_W  effective address, or ALU result for non-memory ops
rs2_data  in  DATA_W  store data, right-aligned
MemRead  in  1  load
MemWrite  in  1  store
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
stall_out  out  1  hold IF..EX/MEM this cycle
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  address, aligned down to DATA_W/8
dmem_be  out  DATA_W/8  byte enables
dmem_wdata  out  DATA_W  store data shifted into the enabled lanes
dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete
mem_valid_out  out  1  one-cycle pulse: result available for MEM/WB
mem_read_data_out  out  DATA_W  extended load data; 0 for stores and non-memory ops
mem_err  out  1  qualifies mem_valid_out: misaligned, illegal, or timeout

Behaviour:
- Reset: on a clk edge with rst=1, go to IDLE and clear all registered outputs to 0. This includes dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_valid_out, mem_read_data_out, mem_err and the timeout counter.
- Reset in REQ abandons the access. A dmem_ack that arrives after reset is ignored.
- Reset has priority over every other event.
- States are IDLE, REQ and RESP.
- IDLE, when ex_valid=1 and (MemRead xor MemWrite):
  - Illegal funct3 (011/110 when DATA_W=32, or 111): go to RESP with mem_err=1 and no bus activity.
  - Misaligned address (H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0): handled per the optional feature.
  - Otherwise latch the address, byte enables, shifted write data, funct3 and byte offset, then go to REQ.
  - stall_out=1 combinationally in this accept cycle.
- IDLE, when ex_valid=1 and MemRead=MemWrite=1: illegal. Go to RESP with mem_err=1, stall_out=1, and no bus activity.
- IDLE, when ex_valid=1 and neither MemRead nor MemWrite: no stall. mem_valid_out=1 on the next cycle with data 0 and err 0; state stays IDLE.
- REQ:
  - dmem_req=1, and dmem_addr, dmem_we, dmem_be and dmem_wdata are stable until ack.
  - stall_out=1.
  - Counter increments every REQ cycle without ack.
  - dmem_ack=1: capture dmem_rdata (loads) and go to RESP.
  - Counter = TIMEOUT_CYCLES without ack: go to RESP with mem_err=1 and drop dmem_req.
- RESP:
  - mem_valid_out=1 for exactly one cycle; stall_out=0; dmem_req=0.
  - Return to IDLE.
  - A new request can be accepted from IDLE on the following cycle.
- Byte enables: B → 1 lane; H → 2 lanes; W → 4 lanes; D → 8 lanes.
- Lane placement: lanes are shifted left by the byte offset, e.g. SB at offset 3 gives be=4'b1000. Write data is replicated or shifted into the same lanes.
- Load data: shift right by the byte offset and select the width. B/H/W sign-extend to DATA_W; BU/HU/WU zero-extend.
- Minimum latency is 2 cycles: accept at T, req at T+1, ack at T+1, mem_valid_out at T+2.
- dmem_ack outside REQ is ignored.

Optional Feature:
Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access causes no bus activity and goes IDLE→RESP with mem_err=1 and mem_read_data_out=0.
- Undefined: a misaligned access is issued with the offset truncated to the access size's natural alignment (e.g. LW at 0x…6 accesses 0x…4) and mem_err=0.

Test Plan:
1. DATA_W=32, LW from 0x100, ack on first REQ cycle with rdata=0xDEADBEEF → stall_out=1 for 2 cycles; dmem_be=4'b1111; mem_valid_out at T+2 with data 0xDEADBEEF, err 0.
2. LB addr 0x103, rdata=0x80FF_0000; then LBU same address → data 0xFFFF_FF80, then 0x0000_0080.
3. SH addr 0x102, rs2=0x1234ABCD, ack delayed 3 cycles → dmem_be=4'b1100, dmem_wdata[31:16]=0xABCD, req held 4 cycles, mem_valid_out then, data 0.
4. TIMEOUT_CYCLES=4, LW, ack never → dmem_req high 4 cycles then low; mem_valid_out with mem_err=1; unit back in IDLE.
5. LW addr 0x101 with LSU_MISALIGN_TRAP_EN → no dmem_req, mem_err=1 one cycle later; without macro → access at 0x100, err 0.
6. rst asserted during REQ, then ack arrives → all outputs 0 after the edge, no mem_valid_out. Also: MemRead=MemWrite=1 → mem_err=1, no dmem_req.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
// MEM-stage load/store unit. Takes the access described by the EX/MEM
// register and turns it into a sized, lane-placed data-memory transaction
// with a req/ack handshake. Load data is shifted down and sign- or
// zero-extended. The pipeline is held while an access is outstanding.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   ex_valid            EX/MEM holds a valid instruction
//   alu_result          effective address (or ALU result for non-memory ops)
//   rs2_data            right-aligned store data
//   MemRead, MemWrite   load / store select (both set is illegal)
//   funct3              access size and signedness
//   stall_out           hold IF..EX/MEM this cycle (combinational)
//   dmem_req/we/addr/be/wdata, dmem_rdata, dmem_ack   data-memory handshake
//   mem_valid_out       one-cycle result pulse toward MEM/WB
//   mem_read_data_out   extended load data, 0 otherwise
//   mem_err             qualifies mem_valid_out: misaligned/illegal/timeout
//
// Build option
//   LSU_MISALIGN_TRAP_EN  defined: misaligned accesses report mem_err with no
//                         bus activity. Undefined: the offset is truncated to
//                         the natural alignment of the access size.
module lsu_mem_stage #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  logic [ADDR_W-1:0]   alu_result,
   input  logic [DATA_W-1:0]   rs2_data,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic [2:0]          funct3,
   output logic                stall_out,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [DATA_W/8-1:0] dmem_be,
   output logic [DATA_W-1:0]   dmem_wdata,
   input  logic [DATA_W-1:0]   dmem_rdata,
   input  logic                dmem_ack,
   output logic                mem_valid_out,
   output logic [DATA_W-1:0]   mem_read_data_out,
   output logic                mem_err
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TrapMisaligned = 1'b1;
`else
   localparam bit TrapMisaligned = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state;
   logic [7:0]        reqCount;
   logic              isLoad;
   logic [2:0]        funct3Q;
   logic [OFF_W-1:0]  offsetQ;

   logic [OFF_W-1:0]  addrOffset;
   logic [OFF_W-1:0]  alignMask;
   logic [OFF_W-1:0]  accessOffset;
   logic [LANES-1:0]  sizeBe;
   logic              illegalSize;
   logic              misaligned;
   logic              memOp;
   logic              timeoutHit;
   logic [DATA_W-1:0] loadShifted;
   logic [DATA_W-1:0] loadExtended;

   // Decode the access size into a lane mask and an alignment mask. The
   // alignment mask both flags misalignment and, when misaligned accesses
   // are not trapped, truncates the byte offset to the natural boundary.
   always_comb begin
      sizeBe    = '0;
      alignMask = '0;
      case (funct3[1:0])
         2'b00:   begin sizeBe = LANES'(1);     alignMask = '0;         end
         2'b01:   begin sizeBe = LANES'(2'b11); alignMask = OFF_W'(1);  end
         2'b10:   begin sizeBe = LANES'(4'hF);  alignMask = OFF_W'(3);  end
         default: begin sizeBe = '1;            alignMask = '1;         end
      endcase
      addrOffset   = alu_result[OFF_W-1:0];
      misaligned   = (addrOffset & alignMask) != '0;
      accessOffset = addrOffset & ~alignMask;
      illegalSize  = (funct3 == 3'b111) ||
                     ((DATA_W == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
      memOp        = MemRead | MemWrite;
      timeoutHit   = (reqCount + 8'd1) == 8'(TIMEOUT_CYCLES);
   end

   // Bring the addressed bytes of the returned word down to bit 0 and extend
   // them according to the latched funct3.
   always_comb begin
      loadShifted  = dmem_rdata >> {offsetQ, 3'b000};
      loadExtended = loadShifted;
      case (funct3Q)
         3'b000:  loadExtended = DATA_W'($signed(loadShifted[7:0]));
         3'b001:  loadExtended = DATA_W'($signed(loadShifted[15:0]));
         3'b010:  loadExtended = DATA_W'($signed(loadShifted[31:0]));
         3'b100:  loadExtended = DATA_W'(loadShifted[7:0]);
         3'b101:  loadExtended = DATA_W'(loadShifted[15:0]);
         3'b110:  loadExtended = DATA_W'(loadShifted[31:0]);
         default: loadExtended = loadShifted;
      endcase
   end

   // The pipeline freezes while a memory op is being accepted and for the
   // whole REQ phase; RESP releases it so the instruction can move on.
   always_comb begin
      stall_out = ((state == IDLE) && ex_valid && memOp) || (state == REQ);
   end

   // Main sequencer. Result outputs default to zero each cycle so that
   // mem_valid_out, mem_err and mem_read_data_out form a single-cycle pulse
   // set on entry to RESP (or on a non-memory pass-through). Bus outputs
   // are only rewritten on accept, so they stay stable through REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         reqCount          <= '0;
         isLoad            <= 1'b0;
         funct3Q           <= '0;
         offsetQ           <= '0;
         dmem_req          <= 1'b0;
         dmem_we           <= 1'b0;
         dmem_addr         <= '0;
         dmem_be           <= '0;
         dmem_wdata        <= '0;
         mem_valid_out     <= 1'b0;
         mem_read_data_out <= '0;
         mem_err           <= 1'b0;
      end else begin
         mem_valid_out     <= 1'b0;
         mem_read_data_out <= '0;
         mem_err           <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (MemRead && MemWrite) begin
                     state         <= RESP;
                     mem_valid_out <= 1'b1;
                     mem_err       <= 1'b1;
                  end else if (!memOp) begin
                     mem_valid_out <= 1'b1;
                  end else if (illegalSize || (TrapMisaligned && misaligned)) begin
                     state         <= RESP;
                     mem_valid_out <= 1'b1;
                     mem_err       <= 1'b1;
                  end else begin
                     state      <= REQ;
                     reqCount   <= '0;
                     isLoad     <= MemRead;
                     funct3Q    <= funct3;
                     offsetQ    <= accessOffset;
                     dmem_req   <= 1'b1;
                     dmem_we    <= MemWrite;
                     dmem_addr  <= {alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     dmem_be    <= sizeBe << accessOffset;
                     dmem_wdata <= rs2_data << {accessOffset, 3'b000};
                  end
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  state             <= RESP;
                  dmem_req          <= 1'b0;
                  dmem_we           <= 1'b0;
                  mem_valid_out     <= 1'b1;
                  mem_read_data_out <= isLoad ? loadExtended : '0;
               end else if (timeoutHit) begin
                  state         <= RESP;
                  dmem_req      <= 1'b0;
                  dmem_we       <= 1'b0;
                  mem_valid_out <= 1'b1;
                  mem_err       <= 1'b1;
               end else begin
                  reqCount <= reqCount + 8'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage
// Directed self-checking bench for lsu_mem_stage (DATA_W=32, TIMEOUT_CYCLES=4).
// Each transaction pushes its expected result onto a scoreboard queue; the
// entry is popped and compared when the unit raises mem_valid_out. Inputs are
// driven on the falling edge and outputs sampled 1 time unit later.
module tb_lsu_mem_stage;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid;
   logic [AW-1:0] alu_result;
   logic [DW-1:0] rs2_data;
   logic          MemRead;
   logic          MemWrite;
   logic [2:0]    funct3;
   logic          stall_out;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [3:0]    dmem_be;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ack;
   logic          mem_valid_out;
   logic [DW-1:0] mem_read_data_out;
   logic          mem_err;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;

   lsu_mem_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .rst               (rst),
      .ex_valid          (ex_valid),
      .alu_result        (alu_result),
      .rs2_data          (rs2_data),
      .MemRead           (MemRead),
      .MemWrite          (MemWrite),
      .funct3            (funct3),
      .stall_out         (stall_out),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_be           (dmem_be),
      .dmem_wdata        (dmem_wdata),
      .dmem_rdata        (dmem_rdata),
      .dmem_ack          (dmem_ack),
      .mem_valid_out     (mem_valid_out),
      .mem_read_data_out (mem_read_data_out),
      .mem_err           (mem_err)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Called in the cycle the result is due: pops the scoreboard and checks
   // the pulse, its payload, the released stall and the pulse width.
   task automatic checkResult(input string tag);
      exp_t e;
      checkOutput({tag, " valid"}, 64'(mem_valid_out), 64'd1);
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checkOutput({tag, " data"}, 64'(mem_read_data_out), 64'(e.data));
         checkOutput({tag, " err"}, 64'(mem_err), 64'(e.err));
      end
      checkOutput({tag, " stall resp"}, 64'(stall_out), 64'd0);
      @(negedge clk);
      #1;
      checkOutput({tag, " valid width"}, 64'(mem_valid_out), 64'd0);
   endtask

   // Drives one instruction, plays the memory side (ack after ackDelay
   // extra REQ cycles, -1 = never), and checks the bus and the result.
   task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int ackDelay,
                                input logic [DW-1:0] rdata, input int expReq,
                                input logic [AW-1:0] expAddr, input logic [3:0] expBe,
                                input logic [DW-1:0] expWdata, input logic [DW-1:0] expData,
                                input logic expErr);
      exp_t e;
      int   reqCycles;
      e.data = expData;
      e.err  = expErr;
      sbQ.push_back(e);
      @(negedge clk);
      ex_valid   = 1'b1;
      MemRead    = rd;
      MemWrite   = wr;
      funct3     = f3;
      alu_result = addr;
      rs2_data   = wdata;
      #1;
      checkOutput({tag, " stall accept"}, 64'(stall_out), 64'(rd | wr));
      reqCycles = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ex_valid = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         #1;
         if (!dmem_req) break;
         reqCycles++;
         if (reqCycles == 1) begin
            checkOutput({tag, " addr"}, 64'(dmem_addr), 64'(expAddr));
            checkOutput({tag, " be"}, 64'(dmem_be), 64'(expBe));
            checkOutput({tag, " wdata"}, 64'(dmem_wdata), 64'(expWdata));
            checkOutput({tag, " we"}, 64'(dmem_we), 64'(wr));
         end
         checkOutput({tag, " stall req"}, 64'(stall_out), 64'd1);
         dmem_ack   = (reqCycles == ackDelay + 1);
         dmem_rdata = rdata;
      end
      dmem_ack = 1'b0;
      checkOutput({tag, " req cycles"}, 64'(reqCycles), 64'(expReq));
      checkResult(tag);
   endtask

   initial begin
      rst        = 1'b1;
      ex_valid   = 1'b0;
      alu_result = '0;
      rs2_data   = '0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      funct3     = '0;
      dmem_rdata = '0;
      dmem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset req", 64'(dmem_req), 64'd0);
      checkOutput("reset addr", 64'(dmem_addr), 64'd0);
      checkOutput("reset be", 64'(dmem_be), 64'd0);
      checkOutput("reset valid", 64'(mem_valid_out), 64'd0);
      checkOutput("reset stall", 64'(stall_out), 64'd0);
      rst = 1'b0;

      //             tag          rd wr f3      addr      wdata         ack rdata          req addr      be     wdata         data          err
      applyStimulus("LW",         1, 0, 3'b010, 32'h100, 32'h0,         0, 32'hDEADBEEF, 1, 32'h100, 4'hF, 32'h0,         32'hDEADBEEF, 0);
      applyStimulus("LB",         1, 0, 3'b000, 32'h103, 32'h0,         1, 32'h80FF0000, 2, 32'h100, 4'h8, 32'h0,         32'hFFFFFF80, 0);
      applyStimulus("LBU",        1, 0, 3'b100, 32'h103, 32'h0,         0, 32'h80FF0000, 1, 32'h100, 4'h8, 32'h0,         32'h00000080, 0);
      applyStimulus("SH",         0, 1, 3'b001, 32'h102, 32'h1234ABCD,  3, 32'h0,        4, 32'h100, 4'hC, 32'hABCD0000,  32'h0,        0);
      applyStimulus("SB",         0, 1, 3'b000, 32'h101, 32'h000000A5,  0, 32'h0,        1, 32'h100, 4'h2, 32'h0000A500,  32'h0,        0);
      applyStimulus("LHU",        1, 0, 3'b101, 32'h102, 32'h0,         0, 32'h80011234, 1, 32'h100, 4'hC, 32'h0,         32'h00008001, 0);
      applyStimulus("LH",         1, 0, 3'b001, 32'h102, 32'h0,         0, 32'h80011234, 1, 32'h100, 4'hC, 32'h0,         32'hFFFF8001, 0);
      applyStimulus("SW",         0, 1, 3'b010, 32'h104, 32'hCAFEBABE,  2, 32'h0,        3, 32'h104, 4'hF, 32'hCAFEBABE,  32'h0,        0);
      applyStimulus("LW timeout", 1, 0, 3'b010, 32'h108, 32'h0,        -1, 32'h0,        TO, 32'h108, 4'hF, 32'h0,        32'h0,        1);
      applyStimulus("non-mem",    0, 0, 3'b010, 32'h55,  32'h0,         0, 32'h0,        0, 32'h0,   4'h0, 32'h0,         32'h0,        0);
      applyStimulus("LD on RV32", 1, 0, 3'b011, 32'h100, 32'h0,         0, 32'h0,        0, 32'h0,   4'h0, 32'h0,         32'h0,        1);
      applyStimulus("f3 111",     0, 1, 3'b111, 32'h100, 32'h0,         0, 32'h0,        0, 32'h0,   4'h0, 32'h0,         32'h0,        1);
      applyStimulus("LWU on RV32",1, 0, 3'b110, 32'h100, 32'h0,         0, 32'h0,        0, 32'h0,   4'h0, 32'h0,         32'h0,        1);
      applyStimulus("rd+wr",      1, 1, 3'b010, 32'h100, 32'h0,         0, 32'h0,        0, 32'h0,   4'h0, 32'h0,         32'h0,        1);
`ifdef LSU_MISALIGN_TRAP_EN
      applyStimulus("LW mis",     1, 0, 3'b010, 32'h101, 32'h0,         0, 32'hCAFEF00D, 0, 32'h0,   4'h0, 32'h0,         32'h0,        1);
      applyStimulus("LH mis",     1, 0, 3'b001, 32'h101, 32'h0,         0, 32'h00009000, 0, 32'h0,   4'h0, 32'h0,         32'h0,        1);
`else
      applyStimulus("LW mis",     1, 0, 3'b010, 32'h101, 32'h0,         0, 32'hCAFEF00D, 1, 32'h100, 4'hF, 32'h0,         32'hCAFEF00D, 0);
      applyStimulus("LH mis",     1, 0, 3'b001, 32'h101, 32'h0,         0, 32'h00009000, 1, 32'h100, 4'h3, 32'h0,         32'hFFFF9000, 0);
`endif

      // Reset while a load is waiting in REQ, then a late ack.
      @(negedge clk);
      ex_valid   = 1'b1;
      MemRead    = 1'b1;
      funct3     = 3'b010;
      alu_result = 32'h200;
      @(negedge clk);
      ex_valid = 1'b0;
      MemRead  = 1'b0;
      #1;
      checkOutput("rst-in-req req before", 64'(dmem_req), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h12345678;
      #1;
      checkOutput("rst-in-req req", 64'(dmem_req), 64'd0);
      checkOutput("rst-in-req addr", 64'(dmem_addr), 64'd0);
      checkOutput("rst-in-req be", 64'(dmem_be), 64'd0);
      checkOutput("rst-in-req valid", 64'(mem_valid_out), 64'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      checkOutput("late ack valid", 64'(mem_valid_out), 64'd0);
      checkOutput("late ack data", 64'(mem_read_data_out), 64'd0);
      checkOutput("late ack req", 64'(dmem_req), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
